// File: rtl/bw_io_edge_pkg.sv
// ---------------------------------------------------------------------------
// bw_io_edge_pkg
// Shared definitions for the CMOS pad edge-logic bank.
//   - Bit positions of the three boundary-scan bits owned by one pad channel.
//   - Helper functions that turn a (data, enable) pair into the pull-up and
//     active-low pull-down drive levels of a CMOS pad.
// ---------------------------------------------------------------------------
package bw_io_edge_pkg;

  // Layout of one boundary-scan cell, LSB nearest the serial output
  localparam int BSR_OE     = 2;
  localparam int BSR_DATA   = 1;
  localparam int BSR_IN     = 0;
  localparam int BSR_CELL_W = 3;

  // Pull-up is on only when enabled and driving a one
  function automatic logic pad_up_f(input logic d, input logic e);
    return d & e;
  endfunction

  // Pull-down (active-low) is on only when enabled and driving a zero,
  // so a disabled pad sits with up=0 / dn_l=1, i.e. tristated
  function automatic logic pad_dn_l_f(input logic d, input logic e);
    return ~(~d & e);
  endfunction

endpackage

// File: rtl/bw_io_cmos_edgelogic_ch.sv
// ---------------------------------------------------------------------------
// bw_io_cmos_edgelogic_ch
// One pad channel of the CMOS edge-logic bank.
//   - Registers core drive data / output enable (1-cycle latency).
//   - Synchronises the asynchronous pad receiver output (2 flops) and
//     glitch-filters it (a level must persist FILT_CNT cycles to pass).
//   - Owns a 3-bit boundary-scan cell {oe, data, in} with capture/shift and
//     a matching set of update latches that can take over the pad and the
//     core-facing receive value while test mode is active.
// Ports
//   clk_i, rst_l_i      clock, asynchronous active-low reset
//   data_i, oe_i        core drive data / output enable
//   rcvr_data_i         pad receiver output (asynchronous)
//   tm_i                test mode: drive/receive from update latches
//   si_i, so_o          serial chain in (from upper neighbour) / out (bit 0)
//   shift_i, capture_i, update_i   boundary-scan controls
//   pad_up_o, pad_dn_l_o          pad drive
//   to_core_o           filtered receive data or update-latch value
// ---------------------------------------------------------------------------
module bw_io_cmos_edgelogic_ch
  import bw_io_edge_pkg::*;
#(
  parameter int FILT_CNT = 4,
  parameter int FILT_W   = 3
) (
  input  logic clk_i,
  input  logic rst_l_i,
  input  logic data_i,
  input  logic oe_i,
  input  logic rcvr_data_i,
  input  logic tm_i,
  input  logic si_i,
  input  logic shift_i,
  input  logic capture_i,
  input  logic update_i,
  output logic pad_up_o,
  output logic pad_dn_l_o,
  output logic to_core_o,
  output logic so_o
);

  logic                  data_q;
  logic                  oe_q;
  logic [1:0]            rs_q;
  logic                  rs;
  logic                  filt;
  logic [BSR_CELL_W-1:0] chain_q;
  logic [BSR_CELL_W-1:0] chain_d;
  logic [BSR_CELL_W-1:0] upd_q;
  logic [BSR_CELL_W-1:0] upd_d;
  logic                  drv_d;
  logic                  drv_e;

  // Functional drive registers and the receive synchroniser
  always_ff @(posedge clk_i or negedge rst_l_i) begin
    if (!rst_l_i) begin
      data_q <= 1'b0;
      oe_q   <= 1'b0;
      rs_q   <= 2'b00;
    end else begin
      data_q <= data_i;
      oe_q   <= oe_i;
      rs_q   <= {rs_q[0], rcvr_data_i};
    end
  end

  assign rs = rs_q[1];

  // Glitch filter: the filtered level only follows the synchronised input
  // once it has disagreed for FILT_CNT consecutive cycles; any agreement
  // restarts the count, so shorter pulses never reach the core.
  if (FILT_CNT == 0) begin : g_nofilt
    assign filt = rs;
  end else begin : g_filt
    localparam logic [FILT_W-1:0] CNT_LAST = FILT_W'(FILT_CNT - 1);

    logic              filt_q;
    logic              filt_d;
    logic [FILT_W-1:0] cnt_q;
    logic [FILT_W-1:0] cnt_d;

    always_comb begin
      filt_d = filt_q;
      cnt_d  = '0;
      if (rs != filt_q) begin
        if (cnt_q == CNT_LAST) begin
          filt_d = rs;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    always_ff @(posedge clk_i or negedge rst_l_i) begin
      if (!rst_l_i) begin
        filt_q <= 1'b0;
        cnt_q  <= '0;
      end else begin
        filt_q <= filt_d;
        cnt_q  <= cnt_d;
      end
    end

    assign filt = filt_q;
  end

  // Scan cell next state: capture wins over shift; shifting moves the cell
  // toward bit 0 with the upstream bit entering at the OE position. Update
  // samples the cell as it stood before this edge, so it composes with a
  // simultaneous capture or shift.
  always_comb begin
    chain_d = chain_q;
    if (capture_i) begin
      chain_d[BSR_OE]   = oe_q;
      chain_d[BSR_DATA] = data_q;
      chain_d[BSR_IN]   = filt;
    end else if (shift_i) begin
      chain_d = {si_i, chain_q[BSR_CELL_W-1:1]};
    end
    upd_d = update_i ? chain_q : upd_q;
  end

  // Scan cell and update latches
  always_ff @(posedge clk_i or negedge rst_l_i) begin
    if (!rst_l_i) begin
      chain_q <= '0;
      upd_q   <= '0;
    end else begin
      chain_q <= chain_d;
      upd_q   <= upd_d;
    end
  end

  // Test mode switches the pad and core-facing values combinationally so a
  // mode change is visible in the same cycle.
  assign drv_d      = tm_i ? upd_q[BSR_DATA] : data_q;
  assign drv_e      = tm_i ? upd_q[BSR_OE]   : oe_q;
  assign pad_up_o   = pad_up_f(drv_d, drv_e);
  assign pad_dn_l_o = pad_dn_l_f(drv_d, drv_e);
  assign to_core_o  = tm_i ? upd_q[BSR_IN] : filt;
  assign so_o       = chain_q[BSR_IN];

endmodule

// File: rtl/bw_io_cmos_edgelogic_bank.sv
// ---------------------------------------------------------------------------
// bw_io_cmos_edgelogic_bank
// Clocked, scan-observable edge logic for a bank of NCH CMOS pads.
// Ports
//   clk_i, rst_l_i        core clock, asynchronous active-low reset
//   data_i, oe_i          core drive data / output enable (NCH)
//   rcvr_data_i           pad receiver outputs, asynchronous (NCH)
//   bsr_mode_i, se_i      boundary-scan mode; scan enable overrides it
//   bsr_si_i, bsr_so_o    boundary-scan serial in / registered serial out
//   bsr_shift_i, bsr_capture_i, bsr_update_i   boundary-scan controls
//   por_l_i               pad power-on reset, active-low, asynchronous
//   pad_up_o, pad_dn_l_o  pad drive (NCH)
//   bsr_up_o, bsr_dn_l_o  observation copies of the pad drive (NCH)
//   to_core_o             filtered receive data or scan data (NCH)
//   por_o                 synchronised power-on reset, active-high
// The scan chain is 3*NCH bits long; channel i owns bits 3i+2..3i and the
// serial input enters at the top of channel NCH-1.
// ---------------------------------------------------------------------------
module bw_io_cmos_edgelogic_bank
  import bw_io_edge_pkg::*;
#(
  parameter int NCH      = 8,
  parameter int FILT_CNT = 4,
  parameter int FILT_W   = 3
) (
  input  logic           clk_i,
  input  logic           rst_l_i,
  input  logic [NCH-1:0] data_i,
  input  logic [NCH-1:0] oe_i,
  input  logic [NCH-1:0] rcvr_data_i,
  input  logic           bsr_mode_i,
  input  logic           se_i,
  input  logic           bsr_si_i,
  input  logic           bsr_shift_i,
  input  logic           bsr_capture_i,
  input  logic           bsr_update_i,
  input  logic           por_l_i,
  output logic [NCH-1:0] pad_up_o,
  output logic [NCH-1:0] pad_dn_l_o,
  output logic [NCH-1:0] bsr_up_o,
  output logic [NCH-1:0] bsr_dn_l_o,
  output logic [NCH-1:0] to_core_o,
  output logic           bsr_so_o,
  output logic           por_o
);

  logic         tm;
  logic [NCH:0] chain_link;
  logic         bsr_so_q;
  logic [1:0]   por_sync_q;
  logic         por_rst_l;

  // Scan enable blocks boundary-scan mode so scan testing of the core sees
  // the functional pad path.
  assign tm = bsr_mode_i & ~se_i;

  // chain_link[i+1] feeds channel i, chain_link[i] is its bit-0 output
  assign chain_link[NCH] = bsr_si_i;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    bw_io_cmos_edgelogic_ch #(
      .FILT_CNT (FILT_CNT),
      .FILT_W   (FILT_W)
    ) u_ch (
      .clk_i       (clk_i),
      .rst_l_i     (rst_l_i),
      .data_i      (data_i[i]),
      .oe_i        (oe_i[i]),
      .rcvr_data_i (rcvr_data_i[i]),
      .tm_i        (tm),
      .si_i        (chain_link[i+1]),
      .shift_i     (bsr_shift_i),
      .capture_i   (bsr_capture_i),
      .update_i    (bsr_update_i),
      .pad_up_o    (pad_up_o[i]),
      .pad_dn_l_o  (pad_dn_l_o[i]),
      .to_core_o   (to_core_o[i]),
      .so_o        (chain_link[i])
    );
  end

  assign bsr_up_o   = pad_up_o;
  assign bsr_dn_l_o = pad_dn_l_o;

  // Serial output is retimed so the chain end never drives off-block
  // straight from a shifting flop.
  always_ff @(posedge clk_i or negedge rst_l_i) begin
    if (!rst_l_i) begin
      bsr_so_q <= 1'b0;
    end else begin
      bsr_so_q <= chain_link[0];
    end
  end

  assign bsr_so_o = bsr_so_q;

  // POR synchroniser: either reset source asserts por immediately, while
  // release ripples through two flops so por falls cleanly on clk.
  assign por_rst_l = rst_l_i & por_l_i;

  always_ff @(posedge clk_i or negedge por_rst_l) begin
    if (!por_rst_l) begin
      por_sync_q <= 2'b11;
    end else begin
      por_sync_q <= {por_sync_q[0], 1'b0};
    end
  end

  assign por_o = por_sync_q[1];

endmodule
